// File: rtl/ram_access_ctrl.sv
// Front-end controller for a 64x8 single-port synchronous RAM.
// Arbitrates valid/ready requests against a full-array fill sequence.
module ram_access_ctrl #(
    parameter int                ADDR_W        = 6,
    parameter int                DATA_W        = 8,
    parameter logic [DATA_W-1:0] FILL_VALUE    = '0,
    parameter bit                FILL_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_start,
    output logic              busy,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [DATA_W-1:0] ram_data_in,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_mode,
    input  logic [DATA_W-1:0] ram_data_out
);

    typedef enum logic {
        FILL,
        RUN
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic              read_pend;

    assign busy      = (state == FILL);
    assign req_ready = (state == RUN) & ~init_start;
    assign rsp_data  = ram_data_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FILL_ON_RESET ? FILL : RUN;
            cnt         <= '0;
            ram_mode    <= 1'b0;
            ram_addr    <= '0;
            ram_data_in <= '0;
            read_pend   <= 1'b0;
            rsp_valid   <= 1'b0;
        end else begin
            // Pending read surfaces one edge after the RAM sampled it
            rsp_valid <= read_pend;
            read_pend <= 1'b0;
            ram_mode  <= 1'b0;
            unique case (state)
                FILL: begin
                    ram_mode    <= 1'b1;
                    ram_addr    <= cnt;
                    ram_data_in <= FILL_VALUE;
                    if (cnt == '1) begin
                        cnt   <= '0;
                        state <= RUN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (init_start) begin
                        state <= FILL;
                        cnt   <= '0;
                    end else if (req_valid) begin
                        ram_mode  <= req_write;
                        ram_addr  <= req_addr;
                        read_pend <= ~req_write;
                        if (req_write) begin
                            ram_data_in <= req_wdata;
                        end
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule
